seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS hex nibbles onto one shared hex-to-7-segment decoder driving a common-segment, per-digit-anode LED display.
- Sequences digit select with dead-time blanking, applies leading-zero suppression and per-digit blanking, and swaps new values in only at frame boundaries so the display never tears.
- Sits between the system's register/counter logic and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- TICK_DIV, 50000, clk cycles each digit is lit (>=2).
- DEAD_CYC, 8, clk cycles all anodes are off between digits (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- value  in  4*NUM_DIGITS  hex digits; nibble i maps to digit i; digit 0 is rightmost/LSB.
- load  in  1  capture value into the pending register this cycle.
- lz_en  in  1  enable leading-zero suppression.
- blank  in  NUM_DIGITS  per-digit force-off mask; 1 = off.
- dp_in  in  NUM_DIGITS  per-digit decimal point; 1 = lit.
- an  out  NUM_DIGITS  digit anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=BLANK, idx=0, cnt=0
  - an=all 1, seg=7'b1111111, dp=1, frame_done=0
  - disp=0, pending=0, pend_v=0
- Reset mid-scan takes effect on that edge. All outputs are registered.
- FSM has two states, BLANK and SHOW. cnt counts up in each state.
- BLANK:
  - an=all 1, seg=7F, dp=1.
  - When cnt==DEAD_CYC-1: go to SHOW, cnt=0.
  - On that same edge: an[idx]=0, seg=decode(disp[idx]), dp=~dp_in[idx].
  - Exception: if digit idx is off, an, seg and dp stay at 1.
- SHOW:
  - Outputs hold for TICK_DIV cycles.
  - When cnt==TICK_DIV-1: go to BLANK, cnt=0, outputs all off.
  - idx advances to idx+1; it wraps to 0 from NUM_DIGITS-1.
- Frame end (the SHOW to BLANK edge with idx==NUM_DIGITS-1):
  - frame_done=1 for exactly one cycle.
  - If pend_v: disp<=pending, pend_v<=0.
- Load:
  - load=1 sets pending<=value, pend_v<=1.
  - Load on the same edge as a frame-end copy: disp takes the old pending; pending takes the new value and pend_v stays 1.
  - Back-to-back loads within a frame: only the last is shown.
- A digit is off if either condition holds:
  - blank[i]=1.
  - Leading-zero suppression: lz_en=1, i>0, and disp nibbles NUM_DIGITS-1 down to i are all zero.
- Digit 0 is never zero-suppressed. An off digit also forces dp off.
- blank, lz_en and dp_in are sampled live at the BLANK to SHOW edge. disp is stable for the whole frame.
- Decode table (active-low, gfedcba):

  | Value | Code | Value | Code |
  |---|---|---|---|
  | 0 | 1000000 | 8 | 0000000 |
  | 1 | 1111001 | 9 | 0010000 |
  | 2 | 0100100 | A | 0001000 |
  | 3 | 0110000 | b | 0000011 |
  | 4 | 0011001 | C | 1000110 |
  | 5 | 0010010 | d | 0100001 |
  | 6 | 0000010 | E | 0000110 |
  | 7 | 1111000 | F | 0001110 |

- Timing:
  - Frame period = NUM_DIGITS*(DEAD_CYC+TICK_DIV) cycles.
  - Latency from load to display: at most one frame plus the current partial frame.
- cnt width is clog2(max(TICK_DIV,DEAD_CYC)); idx width is clog2(NUM_DIGITS).

Decomposition:
- Shared package seg_pkg holds:
  - State enum {BLANK, SHOW}.
  - SEG_OFF=7'h7F.
  - Constants for the 16 decode codes.
- One sub-module, seg7_decode: combinational 4-bit to 7-bit active-low decoder per the table above. Instantiated once and fed by the disp nibble mux.

Test Plan:
Bench parameters: NUM_DIGITS=4, TICK_DIV=4, DEAD_CYC=1.
- Reset checks:
  - Hold rst_n=0 for 3 cycles -> an=4'b1111, seg=7F, dp=1, frame_done=0.
  - Release -> first SHOW begins after 1 cycle with an=4'b1110, seg=1000000 (disp=0).
- Scan order and swap:
  - Load value=16'h12A4 in frame 0 -> frame_done pulses every 20 cycles.
  - From frame 1: an cycles 1110, 1101, 1011, 0111 with seg 0011001, 0001000, 0100100, 1111001, and a 1-cycle all-off gap between digits.
- Leading-zero suppression:
  - value=16'h0050, lz_en=1 -> digits 3 and 2 stay an=1, seg=7F; digit 1 shows 0010010; digit 0 shows 1000000.
  - value=16'h0000 -> only digit 0 is lit.
- Blank and decimal point:
  - blank=4'b0010, dp_in=4'b0011 -> digit 1 fully off (including dp); digit 0 has dp=0; digits 2 and 3 have dp=1.
- Load collision:
  - Pulse load with 16'hAAAA, then load with 16'hBBBB on the frame_done edge -> next frame shows AAAA, the following frame shows BBBB.
- Reset during SHOW:
  - Assert rst_n=0 while digit 2 is lit -> next edge gives all outputs off and idx=0.
  - disp=0 after release, and the loaded value is discarded.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
package seg_pkg;

  // Scan sequencer states: all anodes off (dead time) or one digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Segment bus order is {g,f,e,d,c,b,a}, active-low (0 = lit).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    // NOTE: default assigned first so every path drives seg_o; no latch can be inferred.
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS nibbles onto one shared decoder with dead-time blanking,
// leading-zero suppression, per-digit blanking and tear-free frame swaps.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_CYC   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_MAX = (TICK_DIV > DEAD_CYC) ? TICK_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_v_q, pend_v_d;

  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic                    digit_off;

  // Shared decoder fed by the nibble of the digit about to be lit.
  assign cur_nib = disp_q[4*idx_q +: 4];

  seg7_decode u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  // Leading-zero mask: digit i is suppressed while every nibble from the top down to i is zero.
  always_comb begin
    lz_mask  = '0;
    // NOTE: blocking assignments here are intentional; zero_run carries a value down the loop.
    zero_run = lz_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (disp_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  assign digit_off = blank[idx_q] | lz_mask[idx_q];

  // Next-state, scan position, registered outputs and display buffer updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;
    disp_d       = disp_q;
    pending_d    = pending_q;
    pend_v_d     = pend_v_q;

    unique case (state_q)
      BLANK: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (!digit_off) begin
            an_d        = '1;
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg;
            dp_d        = ~dp_in[idx_q];
          end
        end
      end
      SHOW: begin
        if (cnt_q == TICK_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          an_d    = '1;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          // Frame boundary: swap in the pending value so no frame mixes old and new digits.
          if (idx_q == IDX_LAST) begin
            frame_done_d = 1'b1;
            if (pend_v_q) begin
              disp_d   = pending_q;
              pend_v_d = 1'b0;
            end
          end
        end
      end
      default: state_d = BLANK;
    endcase

    // A load on the swap edge wins over clearing pend_v: the new value waits for the next frame.
    if (load) begin
      pending_d = value;
      pend_v_d  = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      disp_q       <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position model plus directed literal checks.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int TICK  = 4;
  localparam int DEAD  = 1;
  localparam int SLOT  = TICK + DEAD;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          lz_en;
  logic [ND-1:0] blank;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state: cycles since reset release and the model's display buffers.
  int          k = 0;
  int          q, d, w;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic        exp_fd  = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TICK),
    .DEAD_CYC   (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .lz_en      (lz_en),
    .blank      (blank),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic dp_e);
    check({name, ".an"}, 32'(an), 32'(an_e));
    check({name, ".seg"}, 32'(seg), 32'(seg_e));
    check({name, ".dp"}, 32'(dp), 32'(dp_e));
  endtask

  // Advance to the falling edge after the n-th post-reset clock edge, with a cycle budget.
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (k < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("goto_reached", 32'(k), 32'(n));
  endtask

  // Highest nibble index holding a nonzero value (0 when all nibbles are zero).
  function automatic int top_nz(input logic [15:0] v);
    int t;
    t = 0;
    for (int n = 0; n < ND; n++)
      if (v[4*n +: 4] != 4'h0) t = n;
    return t;
  endfunction

  // Model: outputs derived from the position within the frame period.
  always @(posedge clk) begin
    if (!rst_n) begin
      k       = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pv    = 1'b0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_fd  = 1'b0;
    end else begin
      k++;
      exp_fd = 1'b0;
      if (k >= DEAD) begin
        q = (k - DEAD) % FRAME;
        d = q / SLOT;
        w = q % SLOT;
        if (w == 0) begin
          if (blank[d] || (lz_en && d > top_nz(m_disp))) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
          end else begin
            exp_an    = 4'hF;
            exp_an[d] = 1'b0;
            exp_seg   = DEC[m_disp[4*d +: 4]];
            exp_dp    = ~dp_in[d];
          end
        end else if (w == TICK) begin
          exp_an  = 4'hF;
          exp_seg = 7'h7F;
          exp_dp  = 1'b1;
          if (d == ND - 1) begin
            exp_fd = 1'b1;
            if (m_pv) begin
              m_disp = m_pend;
              m_pv   = 1'b0;
            end
          end
        end
      end
      if (load) begin
        m_pend = value;
        m_pv   = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model.an", 32'(an), 32'(exp_an));
      check("model.seg", 32'(seg), 32'(exp_seg));
      check("model.dp", 32'(dp), 32'(exp_dp));
      check("model.frame_done", 32'(frame_done), 32'(exp_fd));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    lz_en = 1'b0;
    blank = '0;
    dp_in = '0;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk_out("reset", 4'b1111, 7'h7F, 1'b1);
    check("reset.frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // First digit lit one edge after release, showing zero.
    goto(1);
    chk_out("first_show", 4'b1110, 7'b1000000, 1'b1);

    // Load 12A4 during frame 0; it appears in frame 1.
    goto(3);
    value = 16'h12A4;
    load  = 1'b1;
    goto(4);
    load  = 1'b0;

    goto(20);
    check("fd_frame0", 32'(frame_done), 32'd1);
    goto(21);
    check("fd_after", 32'(frame_done), 32'd0);
    chk_out("f1_d0", 4'b1110, 7'b0011001, 1'b1);
    goto(25);
    chk_out("f1_gap", 4'b1111, 7'h7F, 1'b1);
    goto(26);
    chk_out("f1_d1", 4'b1101, 7'b0001000, 1'b1);
    goto(31);
    chk_out("f1_d2", 4'b1011, 7'b0100100, 1'b1);
    goto(36);
    chk_out("f1_d3", 4'b0111, 7'b1111001, 1'b1);

    // Leading-zero suppression with 0050.
    goto(38);
    value = 16'h0050;
    load  = 1'b1;
    lz_en = 1'b1;
    goto(39);
    load  = 1'b0;
    check("fd_mid", 32'(frame_done), 32'd0);
    goto(40);
    check("fd_frame1", 32'(frame_done), 32'd1);
    goto(41);
    chk_out("lz_d0", 4'b1110, 7'b1000000, 1'b1);
    goto(45);
    value = 16'h0000;
    load  = 1'b1;
    goto(46);
    load  = 1'b0;
    chk_out("lz_d1", 4'b1101, 7'b0010010, 1'b1);
    goto(51);
    chk_out("lz_d2", 4'b1111, 7'h7F, 1'b1);
    goto(56);
    chk_out("lz_d3", 4'b1111, 7'h7F, 1'b1);

    // All-zero value: only digit 0 lit.
    goto(61);
    chk_out("zero_d0", 4'b1110, 7'b1000000, 1'b1);
    goto(65);
    value = 16'h5678;
    load  = 1'b1;
    goto(66);
    load  = 1'b0;
    chk_out("zero_d1", 4'b1111, 7'h7F, 1'b1);
    goto(71);
    chk_out("zero_d2", 4'b1111, 7'h7F, 1'b1);
    goto(76);
    chk_out("zero_d3", 4'b1111, 7'h7F, 1'b1);

    // Per-digit blank and decimal points with 5678.
    goto(79);
    blank = 4'b0010;
    dp_in = 4'b0011;
    lz_en = 1'b0;
    goto(81);
    chk_out("bdp_d0", 4'b1110, 7'b0000000, 1'b0);
    goto(86);
    chk_out("bdp_d1", 4'b1111, 7'h7F, 1'b1);
    goto(91);
    chk_out("bdp_d2", 4'b1011, 7'b0000010, 1'b1);
    goto(96);
    chk_out("bdp_d3", 4'b0111, 7'b0010010, 1'b1);
    goto(100);
    blank = '0;
    dp_in = '0;

    // Load collision on the frame-end edge.
    goto(105);
    value = 16'hAAAA;
    load  = 1'b1;
    goto(106);
    load  = 1'b0;
    goto(119);
    value = 16'hBBBB;
    load  = 1'b1;
    goto(120);
    load  = 1'b0;
    check("fd_collide", 32'(frame_done), 32'd1);
    goto(121);
    chk_out("coll_a", 4'b1110, 7'b0001000, 1'b1);
    goto(141);
    chk_out("coll_b0", 4'b1110, 7'b0000011, 1'b1);
    goto(146);
    chk_out("coll_b1", 4'b1101, 7'b0000011, 1'b1);

    // Reset while digit 2 is lit, with a pending load that must be discarded.
    goto(148);
    value = 16'hCCCC;
    load  = 1'b1;
    goto(149);
    load  = 1'b0;
    goto(152);
    chk_out("pre_rst_d2", 4'b1011, 7'b0000011, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("mid_rst", 4'b1111, 7'h7F, 1'b1);
    check("mid_rst.frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    goto(1);
    chk_out("post_rst_d0", 4'b1110, 7'b1000000, 1'b1);
    goto(21);
    chk_out("post_rst_f1_d0", 4'b1110, 7'b1000000, 1'b1);
    goto(26);
    chk_out("post_rst_f1_d1", 4'b1101, 7'b1000000, 1'b1);
    goto(30);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
